// File: rtl/sauria_cfg_mem_arbiter.sv
// -----------------------------------------------------------------------------
// sauria_cfg_mem_arbiter
//
// Shares SAURIA's internal address space between the host configuration port
// (requester 0) and the DMA (requester 1). Round-robin arbitration with one
// transaction in flight. The winning address is decoded into a one-hot target
// strobe and a single-cycle response is returned to the issuing requester.
//
// Optional feature macro: SAURIA_XHEEP_PERIPH_EN
//   defined   -> NTGT = 9, region 0x7_0000 decodes to target 8 (XHEEP)
//   undefined -> NTGT = 8, region 0x7_0000 is unmapped (err response)
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_req/i_addr/i_we/    per-requester request bundle, requester r in
//   i_wdata/i_be          slice r; request is held until granted
//   o_gnt                 one-hot grant pulse (combinational in IDLE)
//   o_rvalid/o_rdata/     one-hot response pulse, read data, error flag
//   o_err
//   o_tgt_sel             one-hot target strobe, one cycle per access
//                         (0 REGS,1 CON,2 ACT,3 WEI,4 OUT,5 SRAMA,6 SRAMB,
//                          7 SRAMC,8 XHEEP)
//   o_tgt_addr/we/wdata/be  latched request fields
//   i_tgt_rdata           per-target read data, target t in slice t
// -----------------------------------------------------------------------------
module sauria_cfg_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LATENCY = 1,
`ifdef SAURIA_XHEEP_PERIPH_EN
  localparam int unsigned NTGT      = 9,
`else
  localparam int unsigned NTGT      = 8,
`endif
  localparam int unsigned BE_W      = DATA_W / 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [1:0]             i_req,
  input  logic [2*ADDR_W-1:0]    i_addr,
  input  logic [1:0]             i_we,
  input  logic [2*DATA_W-1:0]    i_wdata,
  input  logic [2*BE_W-1:0]      i_be,
  output logic [1:0]             o_gnt,
  output logic [1:0]             o_rvalid,
  output logic [DATA_W-1:0]      o_rdata,
  output logic                   o_err,
  output logic [NTGT-1:0]        o_tgt_sel,
  output logic [ADDR_W-1:0]      o_tgt_addr,
  output logic                   o_tgt_we,
  output logic [DATA_W-1:0]      o_tgt_wdata,
  output logic [BE_W-1:0]        o_tgt_be,
  input  logic [NTGT*DATA_W-1:0] i_tgt_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q;
  logic              rr_q;      // requester that has priority next
  logic              id_q;      // requester owning the current transaction
  logic              err_q;
  logic [1:0]        rvalid_q;
  logic [2:0]        cnt_q;
  logic [NTGT-1:0]   tgt_sel_q; // one-cycle strobe
  logic [NTGT-1:0]   hit_q;     // held copy of the decoded target for rdata
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
  logic              any_req;
  logic              win_id;
  logic [ADDR_W-1:0] win_addr;
  logic              win_we;
  logic [DATA_W-1:0] win_wdata;
  logic [BE_W-1:0]   win_be;

  always_comb begin
    any_req   = |i_req;
    win_id    = i_req[rr_q] ? rr_q : ~rr_q;
    win_addr  = win_id ? i_addr[2*ADDR_W-1:ADDR_W]   : i_addr[ADDR_W-1:0];
    win_we    = win_id ? i_we[1]                     : i_we[0];
    win_wdata = win_id ? i_wdata[2*DATA_W-1:DATA_W]  : i_wdata[DATA_W-1:0];
    win_be    = win_id ? i_be[2*BE_W-1:BE_W]         : i_be[BE_W-1:0];
  end

  // Grant is only offered in IDLE; reset masks it so every output is 0 while
  // reset is held.
  always_comb begin
    o_gnt = 2'b00;
    if (!i_rst && state_q == StIdle && any_req) begin
      o_gnt[win_id] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Address decode. Only bits [19:9] take part; higher bits alias.
  // ---------------------------------------------------------------------------
  logic [NTGT-1:0] dec_sel;
  logic            dec_err;

  always_comb begin
    dec_sel = '0;
    dec_err = 1'b0;
    case (win_addr[19:16])
      4'h0: begin
        case (win_addr[15:9])
          7'd0:    dec_sel[0] = 1'b1; // REGS 0x0000
          7'd1:    dec_sel[1] = 1'b1; // CON  0x0200
          7'd2:    dec_sel[2] = 1'b1; // ACT  0x0400
          7'd3:    dec_sel[3] = 1'b1; // WEI  0x0600
          7'd4:    dec_sel[4] = 1'b1; // OUT  0x0800
          default: dec_err    = 1'b1;
        endcase
      end
      4'h1:    dec_sel[5] = 1'b1;     // SRAMA
      4'h2:    dec_sel[6] = 1'b1;     // SRAMB
      4'h3:    dec_sel[7] = 1'b1;     // SRAMC
`ifdef SAURIA_XHEEP_PERIPH_EN
      4'h7:    dec_sel[8] = 1'b1;     // XHEEP peripheral window
`endif
      default: dec_err    = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      rr_q      <= 1'b0;
      id_q      <= 1'b0;
      err_q     <= 1'b0;
      rvalid_q  <= 2'b00;
      cnt_q     <= 3'd0;
      tgt_sel_q <= '0;
      hit_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            id_q    <= win_id;
            rr_q    <= ~win_id;
            addr_q  <= win_addr;
            we_q    <= win_we;
            wdata_q <= win_wdata;
            be_q    <= win_be;
            hit_q   <= dec_sel;
            if (dec_err) begin
              // Unmapped: skip the target entirely and respond next cycle.
              err_q            <= 1'b1;
              rvalid_q[win_id] <= 1'b1;
              state_q          <= StResp;
            end else begin
              err_q     <= 1'b0;
              tgt_sel_q <= dec_sel;
              state_q   <= StIssue;
            end
          end
        end

        StIssue: begin
          tgt_sel_q <= '0;
          cnt_q     <= 3'(RD_LATENCY - 1);
          if (RD_LATENCY == 1) begin
            rvalid_q[id_q] <= 1'b1;
            state_q        <= StResp;
          end else begin
            state_q <= StWait;
          end
        end

        StWait: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            rvalid_q[id_q] <= 1'b1;
            state_q        <= StResp;
          end
        end

        StResp: begin
          rvalid_q <= 2'b00;
          err_q    <= 1'b0;
          state_q  <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Response data: AND-OR mux over the held one-hot target. Target rdata is
  // valid in the RESP cycle, so it is passed through rather than registered.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] sel_rdata;

  always_comb begin
    sel_rdata = '0;
    for (int t = 0; t < NTGT; t++) begin
      if (hit_q[t]) begin
        sel_rdata = sel_rdata | i_tgt_rdata[t*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    if (state_q == StResp && !we_q && !err_q) begin
      o_rdata = sel_rdata;
    end
  end

  assign o_rvalid    = rvalid_q;
  assign o_err       = err_q;
  assign o_tgt_sel   = tgt_sel_q;
  assign o_tgt_addr  = addr_q;
  assign o_tgt_we    = we_q;
  assign o_tgt_wdata = wdata_q;
  assign o_tgt_be    = be_q;

endmodule
